eth_mac_tx: RTL and testbench

//  Byte-wide Ethernet transmit MAC. Sits directly downstream of the Ethernet header framer.

---
 rtl/eth_pkg.sv | 28 ++
 rtl/eth_crc32_byte.sv | 17 +
 rtl/eth_mac_tx.sv | 193 +++++++++++++++++++
 tb/tb_eth_mac_tx.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants, FSM state encoding and beat payload for the TX MAC and RX checker.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  ETH_SFD_BYTE        = 8'hD5;
  localparam logic [31:0] ETH_CRC32_POLY      = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam int unsigned ETH_MIN_FRAME_BYTES = 60;
  localparam int unsigned ETH_PREAMBLE_BEATS  = 7;
  localparam int unsigned ETH_FCS_BYTES       = 4;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } eth_tx_state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } eth_beat_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte step of the reflected IEEE 802.3 CRC-32 (no final inversion).
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] next_crc
);

  always_comb begin
    next_crc = crc;
    for (int i = 0; i < 8; i++) begin
      next_crc = (next_crc >> 1) ^ (ETH_CRC32_POLY & {32{next_crc[0] ^ data[i]}});
    end
  end

endmodule

// File: rtl/eth_mac_tx.sv
// Byte-wide Ethernet TX MAC: preamble/SFD, pass-through data, optional pad, FCS, inter-frame gap.
// Build option ETH_MAC_TX_PAD_EN enables zero-padding of short frames to MIN_FRAME_BYTES.
module eth_mac_tx
  import eth_pkg::*;
#(
`ifdef ETH_MAC_TX_PAD_EN
  parameter int unsigned MIN_FRAME_BYTES = ETH_MIN_FRAME_BYTES,
`endif
  parameter int unsigned IFG_BYTES = 12
) (
  input  logic       clk,
  input  logic       aresetn,
  output logic       axis_i_tready,
  input  logic       axis_i_tvalid,
  input  logic       axis_i_tlast,
  input  logic       axis_i_tkeep,
  input  logic [7:0] axis_i_tdata,
  input  logic       axis_o_tready,
  output logic       axis_o_tvalid,
  output logic       axis_o_tlast,
  output logic       axis_o_tkeep,
  output logic [7:0] axis_o_tdata
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned BEAT_W = 3;
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'((IFG_BYTES == 0) ? 0 : IFG_BYTES - 1);
  localparam logic [BEAT_W-1:0] PRE_LAST = BEAT_W'(ETH_PREAMBLE_BEATS - 1);
  localparam logic [BEAT_W-1:0] FCS_LAST = BEAT_W'(ETH_FCS_BYTES - 1);

  eth_tx_state_t     state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  ifg_q, ifg_d;
  logic [CNT_W-1:0]  bytes_q, bytes_d;
  logic [31:0]       crc_q, crc_d;

  logic [7:0]        crc_in;
  logic [31:0]       crc_next;
  logic [31:0]       fcs;
  logic [CNT_W-1:0]  bytes_inc;
  logic              frame_done;
  eth_beat_t         beat_out;

  // Pad beats feed zeros into the CRC; data beats feed the input byte.
  assign crc_in    = (state_q == PAD) ? 8'h00 : axis_i_tdata;
  assign fcs       = ~crc_q;
  assign bytes_inc = (bytes_q == {CNT_W{1'b1}}) ? bytes_q : bytes_q + CNT_W'(1);

  eth_crc32_byte u_crc (
    .crc      (crc_q),
    .data     (crc_in),
    .next_crc (crc_next)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      beat_q  <= '0;
      ifg_q   <= '0;
      bytes_q <= '0;
      crc_q   <= ETH_CRC32_INIT;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ifg_q   <= ifg_d;
      bytes_q <= bytes_d;
      crc_q   <= crc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    ifg_d         = ifg_q;
    bytes_d       = bytes_q;
    crc_d         = crc_q;
    frame_done    = 1'b0;
    axis_i_tready = 1'b0;
    axis_o_tvalid = 1'b0;
    beat_out      = '{last: 1'b0, data: 8'h00};

    case (state_q)
      IDLE: begin
        if (axis_i_tvalid) begin
          state_d = PREAMBLE;
          beat_d  = '0;
          crc_d   = ETH_CRC32_INIT;
        end
      end

      PREAMBLE: begin
        axis_o_tvalid = 1'b1;
        beat_out.data = ETH_PREAMBLE_BYTE;
        if (axis_o_tready) begin
          if (beat_q == PRE_LAST) begin
            state_d = SFD;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      SFD: begin
        axis_o_tvalid = 1'b1;
        beat_out.data = ETH_SFD_BYTE;
        if (axis_o_tready) begin
          state_d = DATA;
          bytes_d = '0;
        end
      end

      // Zero-latency pass-through; discarded (tkeep=0) beats are swallowed without the line.
      DATA: begin
        axis_o_tvalid = axis_i_tvalid & axis_i_tkeep;
        axis_i_tready = axis_o_tready | ~axis_i_tkeep;
        beat_out.data = axis_i_tdata;
        if (axis_i_tvalid && axis_i_tready) begin
          if (axis_i_tkeep) begin
            bytes_d = bytes_inc;
            crc_d   = crc_next;
          end
          if (axis_i_tlast) begin
            beat_d = '0;
`ifdef ETH_MAC_TX_PAD_EN
            state_d = (bytes_d < CNT_W'(MIN_FRAME_BYTES)) ? PAD : FCS;
`else
            state_d = FCS;
`endif
          end
        end
      end

`ifdef ETH_MAC_TX_PAD_EN
      PAD: begin
        axis_o_tvalid = 1'b1;
        if (axis_o_tready) begin
          bytes_d = bytes_inc;
          crc_d   = crc_next;
          if (bytes_inc >= CNT_W'(MIN_FRAME_BYTES)) begin
            state_d = FCS;
          end
        end
      end
`endif

      FCS: begin
        axis_o_tvalid = 1'b1;
        beat_out.last = (beat_q == FCS_LAST);
        case (beat_q[1:0])
          2'd0:    beat_out.data = fcs[7:0];
          2'd1:    beat_out.data = fcs[15:8];
          2'd2:    beat_out.data = fcs[23:16];
          default: beat_out.data = fcs[31:24];
        endcase
        if (axis_o_tready) begin
          if (beat_q == FCS_LAST) begin
            if (IFG_BYTES == 0) begin
              frame_done = 1'b1;
            end else begin
              state_d = IFG;
              ifg_d   = '0;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      IFG: begin
        if (ifg_q == IFG_LAST) begin
          frame_done = 1'b1;
        end else begin
          ifg_d = ifg_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Skip the IDLE cycle when the next frame is already waiting, so the gap is exactly IFG_BYTES.
    if (frame_done) begin
      state_d = axis_i_tvalid ? PREAMBLE : IDLE;
      beat_d  = '0;
      crc_d   = ETH_CRC32_INIT;
    end
  end

  assign axis_o_tlast = beat_out.last;
  assign axis_o_tdata = beat_out.data;
  assign axis_o_tkeep = axis_o_tvalid;

endmodule

// File: tb/tb_eth_mac_tx.sv
// Scoreboard bench for eth_mac_tx: expected line bytes queued at drive time, popped on handshakes.
module tb_eth_mac_tx;

  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
`ifdef ETH_MAC_TX_PAD_EN
  localparam int PAD_ON = 1;
`else
  localparam int PAD_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       aresetn;
  logic       i_tvalid, i_tlast, i_tkeep;
  logic [7:0] i_tdata;
  logic       o_tready;
  logic       sel;

  logic       a_i_tready, a_o_tvalid, a_o_tlast, a_o_tkeep;
  logic [7:0] a_o_tdata;
  logic       b_i_tready, b_o_tvalid, b_o_tlast, b_o_tkeep;
  logic [7:0] b_o_tdata;

  logic       s_i_tready, s_o_tvalid, s_o_tlast;
  logic [7:0] s_o_tdata;

  assign s_i_tready = sel ? b_i_tready : a_i_tready;
  assign s_o_tvalid = sel ? b_o_tvalid : a_o_tvalid;
  assign s_o_tlast  = sel ? b_o_tlast  : a_o_tlast;
  assign s_o_tdata  = sel ? b_o_tdata  : a_o_tdata;

  eth_mac_tx #(.IFG_BYTES(12)) u_dut_a (
    .clk (clk), .aresetn (aresetn),
    .axis_i_tready (a_i_tready), .axis_i_tvalid (i_tvalid), .axis_i_tlast (i_tlast),
    .axis_i_tkeep (i_tkeep), .axis_i_tdata (i_tdata),
    .axis_o_tready (o_tready), .axis_o_tvalid (a_o_tvalid), .axis_o_tlast (a_o_tlast),
    .axis_o_tkeep (a_o_tkeep), .axis_o_tdata (a_o_tdata)
  );

  eth_mac_tx #(.IFG_BYTES(0)) u_dut_b (
    .clk (clk), .aresetn (aresetn),
    .axis_i_tready (b_i_tready), .axis_i_tvalid (i_tvalid), .axis_i_tlast (i_tlast),
    .axis_i_tkeep (i_tkeep), .axis_i_tdata (i_tdata),
    .axis_o_tready (o_tready), .axis_o_tvalid (b_o_tvalid), .axis_o_tlast (b_o_tlast),
    .axis_o_tkeep (b_o_tkeep), .axis_o_tdata (b_o_tdata)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [8:0] sb[$];
  logic [7:0] rx_q[$];
  logic [7:0] tx_d[$];
  logic       tx_k[$];
  bit         mon_en = 1'b1;
  bit         rnd_rdy = 1'b0;
  int         beats = 0;
  int         last_beats = -1;
  bit         gap_meas = 1'b0;
  int         gap = 0;
  int         last_gap = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Reference frame on the line: preamble, SFD, kept bytes, optional pad, inverted CRC LSB first.
  task automatic push_expected();
    logic [31:0] c;
    int n;
    c = 32'hFFFFFFFF;
    n = 0;
    repeat (7) sb.push_back({1'b0, 8'h55});
    sb.push_back({1'b0, 8'hD5});
    foreach (tx_d[i]) begin
      if (tx_k[i]) begin
        sb.push_back({1'b0, tx_d[i]});
        c = crc_byte(c, tx_d[i]);
        n++;
      end
    end
    if (PAD_ON != 0) begin
      while (n < 60) begin
        sb.push_back(9'h000);
        c = crc_byte(c, 8'h00);
        n++;
      end
    end
    c = ~c;
    for (int k = 0; k < 4; k++) sb.push_back({k == 3, c[8*k +: 8]});
  endtask

  task automatic send_beat(input logic [7:0] d, input logic k, input logic l, output bit acc);
    i_tvalid = 1'b1;
    i_tdata  = d;
    i_tkeep  = k;
    i_tlast  = l;
    acc      = 1'b0;
    for (int c = 0; c < 1000 && !acc; c++) begin
      @(negedge clk);
      acc = s_i_tready;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input string tag, input bit gaps);
    bit acc, ok;
    ok = 1'b1;
    foreach (tx_d[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        i_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_beat(tx_d[i], tx_k[i], i == tx_d.size() - 1, acc);
      ok &= acc;
    end
    check({tag, "_accept"}, 32'(ok), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int c = 0; c < 5000 && sb.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic load_frame(input int n, input int kind);
    tx_d.delete();
    tx_k.delete();
    for (int i = 0; i < n; i++) begin
      tx_d.push_back((kind == 0) ? 8'(i) : 8'($urandom_range(0, 255)));
      tx_k.push_back(1'b1);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      o_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: sample mid-cycle, compare every handshake against the scoreboard.
  initial begin
    logic [31:0] exp, c;
    forever begin
      @(negedge clk);
      if (mon_en && aresetn) begin
        if (gap_meas) begin
          if (!s_o_tvalid) gap++;
          else begin
            last_gap = gap;
            gap_meas = 1'b0;
          end
        end
        if (s_o_tvalid && o_tready) begin
          beats++;
          if (sb.size() > 0) exp = {23'd0, sb.pop_front()};
          else               exp = 'x;
          check("beat", {23'd0, s_o_tlast, s_o_tdata}, exp);
          rx_q.push_back(s_o_tdata);
          if (s_o_tlast) begin
            c = 32'hFFFFFFFF;
            for (int j = 8; j < rx_q.size(); j++) c = crc_byte(c, rx_q[j]);
            check("residue", c, RESIDUE);
            rx_q.delete();
            last_beats = beats;
            beats = 0;
            gap_meas = 1'b1;
            gap = 0;
          end
        end
      end
    end
  end

  initial begin
    bit acc;
    aresetn  = 1'b0;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    i_tkeep  = 1'b0;
    i_tdata  = 8'h00;
    o_tready = 1'b1;
    sel      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_tvalid", 32'(a_o_tvalid), 32'd0);
    check("rst_o_tlast",  32'(a_o_tlast),  32'd0);
    check("rst_o_tdata",  32'(a_o_tdata),  32'd0);
    check("rst_i_tready", 32'(a_i_tready), 32'd0);
    aresetn = 1'b1;
    idle_cycles(2);

    // "123456789"
    tx_d.delete();
    tx_k.delete();
    for (int i = 0; i < 9; i++) begin
      tx_d.push_back(8'h31 + 8'(i));
      tx_k.push_back(1'b1);
    end
    if (PAD_ON == 0) begin
      repeat (7) sb.push_back({1'b0, 8'h55});
      sb.push_back({1'b0, 8'hD5});
      foreach (tx_d[i]) sb.push_back({1'b0, tx_d[i]});
      sb.push_back(9'h026);
      sb.push_back(9'h039);
      sb.push_back(9'h0F4);
      sb.push_back(9'h1CB);
    end else begin
      push_expected();
    end
    send_frame("t1", 1'b0);
    idle_cycles(1);
    wait_drain("t1");
    check("t1_beats", 32'(last_beats), (PAD_ON != 0) ? 32'd72 : 32'd21);

    // Short frame 00..0D
    load_frame(14, 0);
    push_expected();
    send_frame("t2", 1'b0);
    idle_cycles(1);
    wait_drain("t2");
    check("t2_beats", 32'(last_beats), (PAD_ON != 0) ? 32'd72 : 32'd26);

    // Random back-pressure and input gaps
    load_frame(64, 1);
    push_expected();
    rnd_rdy = 1'b1;
    send_frame("t3", 1'b1);
    idle_cycles(1);
    wait_drain("t3");
    rnd_rdy = 1'b0;
    idle_cycles(20);
    check("t3_beats", 32'(last_beats), 32'd76);

    // Back-to-back frames, 12-cycle gap
    last_gap = -1;
    load_frame(60, 1);
    push_expected();
    send_frame("t4a0", 1'b0);
    load_frame(60, 1);
    push_expected();
    send_frame("t4a1", 1'b0);
    idle_cycles(1);
    wait_drain("t4a");
    check("t4_gap12", 32'(last_gap), 32'd12);

    // Same with the zero-gap instance
    idle_cycles(20);
    aresetn = 1'b0;
    sel = 1'b1;
    idle_cycles(2);
    aresetn = 1'b1;
    idle_cycles(2);
    last_gap = -1;
    load_frame(60, 1);
    push_expected();
    send_frame("t4b0", 1'b0);
    load_frame(60, 1);
    push_expected();
    send_frame("t4b1", 1'b0);
    idle_cycles(1);
    wait_drain("t4b");
    check("t4_gap0", 32'(last_gap), 32'd0);
    idle_cycles(4);
    aresetn = 1'b0;
    sel = 1'b0;
    idle_cycles(2);
    aresetn = 1'b1;
    idle_cycles(2);

    // 59 kept bytes, then a discarded tlast beat
    load_frame(59, 1);
    tx_d.push_back(8'hAA);
    tx_k.push_back(1'b0);
    push_expected();
    send_frame("t6", 1'b0);
    idle_cycles(1);
    wait_drain("t6");
    check("t6_beats", 32'(last_beats), (PAD_ON != 0) ? 32'd72 : 32'd71);
    idle_cycles(20);

    // Reset during data byte 20, then a clean frame
    load_frame(60, 1);
    mon_en = 1'b0;
    for (int i = 0; i < 20; i++) send_beat(tx_d[i], 1'b1, 1'b0, acc);
    i_tvalid = 1'b1;
    i_tdata  = tx_d[20];
    #1;
    check("t5_in_data", 32'(a_o_tvalid), 32'd1);
    aresetn = 1'b0;
    #1;
    check("t5_rst_tvalid", 32'(a_o_tvalid), 32'd0);
    check("t5_rst_tready", 32'(a_i_tready), 32'd0);
    idle_cycles(2);
    aresetn = 1'b1;
    rx_q.delete();
    beats = 0;
    gap_meas = 1'b0;
    mon_en = 1'b1;
    idle_cycles(1);
    load_frame(60, 1);
    push_expected();
    send_frame("t5", 1'b0);
    idle_cycles(1);
    wait_drain("t5");
    check("t5_beats", 32'(last_beats), 32'd72);

    idle_cycles(4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
